// File: rtl/wfifo_defs.sv
// rtl/wfifo_defs.sv - shared constants and helpers for the wide-to-halfword write FIFO
package wfifo_defs;

  localparam int HALF_W  = 16;
  localparam int HSTRB_W = 2;

  // Stored entry: {last, strobes, data}
  function automatic int entry_w(input int w);
    return w + w / 8 + 1;
  endfunction

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wfifo_sdp_ram.sv
// rtl/wfifo_sdp_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
module wfifo_sdp_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wfifo_sc.sv
// rtl/wfifo_sc.sv - single-clock write FIFO, wide beats in, 16-bit halfwords out (FWFT)
module wfifo_sc
  import wfifo_defs::*;
#(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int FIFO_DEPTH     = 512,
  parameter int AFULL_THRESH   = FIFO_DEPTH - 4
) (
  input  logic                              fifo_clk,
  input  logic                              fifo_rst,
  input  logic [DATA_BUS_WIDTH-1:0]         fifo_wr_din,
  input  logic [DATA_BUS_WIDTH/8-1:0]       fifo_wr_strb,
  input  logic                              fifo_wr_last,
  input  logic                              fifo_wr_ena,
  output logic                              fifo_wr_full,
  output logic                              fifo_wr_afull,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_wr_level,
  output logic                              fifo_wr_ovf,
  output logic [HALF_W-1:0]                 fifo_rd_dout,
  output logic [HSTRB_W-1:0]                fifo_rd_strb,
  output logic                              fifo_rd_last,
  input  logic                              fifo_rd_en,
  output logic                              fifo_rd_empty
);

  localparam int LANES  = DATA_BUS_WIDTH / HALF_W;
  localparam int STRB_W = DATA_BUS_WIDTH / 8;
  localparam int EW     = entry_w(DATA_BUS_WIDTH);
  localparam int AW     = clog2(FIFO_DEPTH);
  localparam int LW     = clog2(FIFO_DEPTH + 1);
  localparam int LCW    = (LANES > 1) ? clog2(LANES) : 1;

  if (DATA_BUS_WIDTH < HALF_W || (DATA_BUS_WIDTH % HALF_W) != 0) begin : g_bad_width
    $error("wfifo_sc: DATA_BUS_WIDTH must be a multiple of 16 and at least 16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wfifo_sc: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_thresh
    $error("wfifo_sc: AFULL_THRESH must lie in 1..FIFO_DEPTH");
  end

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [LW-1:0]  level_nxt;
  logic [LCW-1:0] lane_cnt;
  logic           full;
  logic           empty;
  logic           afull;
  logic           ovf;

  logic           push;
  logic           rd_ok;
  logic           lane_end;
  logic           pop;
  logic [EW-1:0]  head;

  // full is the registered flag, so a same-cycle pop never frees room for a write
  assign push     = fifo_wr_ena & ~full;
  assign rd_ok    = fifo_rd_en & ~empty;
  assign lane_end = (lane_cnt == LCW'(LANES - 1));
  assign pop      = rd_ok & lane_end;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LW'(1);
    else if (pop && !push) level_nxt = level - LW'(1);
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      lane_cnt <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      afull    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (rd_ok) lane_cnt <= lane_end ? '0 : lane_cnt + LCW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(FIFO_DEPTH));
      empty <= (level_nxt == '0);
      afull <= (level_nxt >= LW'(AFULL_THRESH));
      ovf   <= ovf | (fifo_wr_ena & full);
    end
  end

  wfifo_sdp_ram #(
    .ADDR_W (AW),
    .DATA_W (EW)
  ) u_ram (
    .clk   (fifo_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({fifo_wr_last, fifo_wr_strb, fifo_wr_din}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  logic [HALF_W-1:0]  lane_d;
  logic [HSTRB_W-1:0] lane_s;

  if (LANES == 1) begin : g_one_lane
    assign lane_d = head[HALF_W-1:0];
    assign lane_s = head[DATA_BUS_WIDTH +: HSTRB_W];
  end else begin : g_multi_lane
    logic [HALF_W-1:0]  d_arr [LANES];
    logic [HSTRB_W-1:0] s_arr [LANES];
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign d_arr[k] = head[HALF_W*k +: HALF_W];
      assign s_arr[k] = head[DATA_BUS_WIDTH + HSTRB_W*k +: HSTRB_W];
    end
    assign lane_d = d_arr[lane_cnt];
    assign lane_s = s_arr[lane_cnt];
  end

  assign fifo_rd_dout  = empty ? '0 : lane_d;
  assign fifo_rd_strb  = empty ? '0 : lane_s;
  assign fifo_rd_last  = ~empty & head[EW-1] & lane_end;
  assign fifo_rd_empty = empty;
  assign fifo_wr_full  = full;
  assign fifo_wr_afull = afull;
  assign fifo_wr_level = level;
  assign fifo_wr_ovf   = ovf;

endmodule

// File: tb/tb_wfifo_sc.sv
// tb/tb_wfifo_sc.sv - randomized and directed bench for wfifo_sc against a queue model
module tb_wfifo_sc;

  localparam int W     = 64;
  localparam int D     = 4;
  localparam int TH    = 3;
  localparam int LANES = W / 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  din;
  logic [W/8-1:0] strb;
  logic          last, ena, rd_en;
  logic          full, afull, ovf, rlast, empty;
  logic [2:0]    level;
  logic [15:0]   dout;
  logic [1:0]    rstrb;

  logic [31:0]   din32;
  logic [3:0]    strb32;
  logic          last32, ena32, rd32;
  logic          full32, afull32, ovf32, rlast32, empty32;
  logic [3:0]    level32;
  logic [15:0]   dout32;
  logic [1:0]    rstrb32;

  wfifo_sc #(.DATA_BUS_WIDTH(W), .FIFO_DEPTH(D), .AFULL_THRESH(TH)) u64 (
    .fifo_clk(clk), .fifo_rst(rst),
    .fifo_wr_din(din), .fifo_wr_strb(strb), .fifo_wr_last(last), .fifo_wr_ena(ena),
    .fifo_wr_full(full), .fifo_wr_afull(afull), .fifo_wr_level(level), .fifo_wr_ovf(ovf),
    .fifo_rd_dout(dout), .fifo_rd_strb(rstrb), .fifo_rd_last(rlast),
    .fifo_rd_en(rd_en), .fifo_rd_empty(empty)
  );

  wfifo_sc #(.DATA_BUS_WIDTH(32), .FIFO_DEPTH(8), .AFULL_THRESH(4)) u32 (
    .fifo_clk(clk), .fifo_rst(rst),
    .fifo_wr_din(din32), .fifo_wr_strb(strb32), .fifo_wr_last(last32), .fifo_wr_ena(ena32),
    .fifo_wr_full(full32), .fifo_wr_afull(afull32), .fifo_wr_level(level32), .fifo_wr_ovf(ovf32),
    .fifo_rd_dout(dout32), .fifo_rd_strb(rstrb32), .fifo_rd_last(rlast32),
    .fifo_rd_en(rd32), .fifo_rd_empty(empty32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of whole beats plus the current halfword index of the head
  typedef struct {
    logic [W-1:0]   d;
    logic [W/8-1:0] s;
    logic           l;
  } beat_t;

  beat_t q[$];
  int    lane    = 0;
  bit    m_ovf   = 0;
  bit    started = 0;

  always @(posedge clk) begin
    bit was_full;
    bit was_empty;
    if (rst) begin
      q.delete();
      lane    = 0;
      m_ovf   = 0;
      started = 1;
    end else if (started) begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (ena && was_full) m_ovf = 1;
      if (rd_en && !was_empty) begin
        if (lane == LANES - 1) begin
          q.delete(0);
          lane = 0;
        end else begin
          lane++;
        end
      end
      if (ena && !was_full) q.push_back('{din, strb, last});
    end
  end

  always @(negedge clk) begin
    logic [63:0] e_d;
    logic [15:0] e_s;
    logic        e_l;
    int          sz;
    if (started) begin
      sz  = q.size();
      e_d = '0;
      e_s = '0;
      e_l = 1'b0;
      if (sz > 0) begin
        e_d = 64'((q[0].d >> (16 * lane)) & 64'hFFFF);
        e_s = 16'((q[0].s >> (2 * lane)) & 8'h3);
        e_l = q[0].l && (lane == LANES - 1);
      end
      chk("m_empty", empty, sz == 0);
      chk("m_full",  full,  sz == D);
      chk("m_afull", afull, sz >= TH);
      chk("m_level", level, sz);
      chk("m_ovf",   ovf,   m_ovf);
      chk("m_dout",  dout,  e_d);
      chk("m_strb",  rstrb, e_s);
      chk("m_last",  rlast, e_l);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; ena = 0; rd_en = 0;
    cyc();
    rst = 0;
  endtask

  function automatic logic [W-1:0] beat_data(input int b);
    logic [W-1:0] v;
    for (int k = 0; k < LANES; k++) v[16*k +: 16] = 16'(16'hA000 + b * 16 + k);
    return v;
  endfunction

  task automatic put(input logic [W-1:0] d, input logic [W/8-1:0] s, input logic l);
    din = d; strb = s; last = l; ena = 1;
    cyc();
    ena = 0;
  endtask

  initial begin
    logic [W-1:0] x;
    rst = 1; din = '0; strb = '0; last = 0; ena = 0; rd_en = 0;
    din32 = '0; strb32 = '0; last32 = 0; ena32 = 0; rd32 = 0;
    cyc(); cyc();
    rst = 0;

    // Reset and idle, rd_en pulses on empty are ignored
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_level", level, 0);
    chk("rst_dout", dout, 0);   chk("rst_ovf", ovf, 0);   chk("rst_afull", afull, 0);
    rd_en = 1; cyc(); cyc(); cyc(); rd_en = 0;
    chk("idle_empty", empty, 1); chk("idle_level", level, 0); chk("idle_dout", dout, 0);

    // 32-bit instance: one beat, two halfwords, lowest lane first
    din32 = 32'hBBBB_AAAA; strb32 = 4'b0110; last32 = 1; ena32 = 1;
    cyc();
    ena32 = 0;
    chk("w32_empty0", empty32, 0); chk("w32_level", level32, 1); chk("w32_full", full32, 0);
    chk("w32_dout0", dout32, 16'hAAAA); chk("w32_strb0", rstrb32, 2'b10); chk("w32_last0", rlast32, 0);
    rd32 = 1; cyc();
    chk("w32_dout1", dout32, 16'hBBBB); chk("w32_strb1", rstrb32, 2'b01); chk("w32_last1", rlast32, 1);
    cyc(); rd32 = 0;
    chk("w32_empty2", empty32, 1); chk("w32_dout2", dout32, 0);
    chk("w32_ovf", ovf32, 0); chk("w32_afull", afull32, 0);

    // Fill to full, overflow, then drain 16 halfwords in order
    for (int b = 0; b < D; b++) begin
      put(beat_data(b), 8'(b * 37 + 1), b[0]);
      chk("fill_level", level, b + 1);
      chk("fill_afull", afull, (b + 1) >= TH);
    end
    chk("fill_full", full, 1); chk("fill_level4", level, 4); chk("fill_ovf0", ovf, 0);
    put(beat_data(9), 8'hFF, 1);
    chk("ovf_set", ovf, 1); chk("ovf_level", level, 4);
    rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", dout, 16'hA000 + (i / 4) * 16 + (i % 4));
      chk("drain_last", rlast, (i % 4 == 3) && ((i / 4) % 2 == 1));
      cyc();
    end
    rd_en = 0;
    chk("drain_empty", empty, 1); chk("drain_ovf_sticky", ovf, 1);

    // Full with last lane pending: same-cycle pop does not admit the write
    do_reset();
    for (int b = 0; b < D; b++) put(beat_data(b + 4), 8'h0F, 0);
    rd_en = 1; cyc(); cyc(); cyc();
    chk("pend_level", level, 4); chk("pend_dout", dout, 16'hA043);
    ena = 1; din = beat_data(15);
    cyc();
    ena = 0; rd_en = 0;
    chk("pend_ovf", ovf, 1); chk("pend_level3", level, 3); chk("pend_full", full, 0);
    chk("pend_head", dout, 16'hA050);

    // Streaming: push aligned with each pop, level stays at 2 across pointer wrap
    do_reset();
    put(beat_data(1), 8'hFF, 0);
    put(beat_data(2), 8'hFF, 1);
    rd_en = 1;
    for (int c = 0; c < 1000 * LANES; c++) begin
      ena  = (c % LANES == LANES - 1);
      din  = {$urandom, $urandom};
      strb = 8'($urandom);
      last = 1'($urandom);
      cyc();
      chk("stream_level", level, 2);
      chk("stream_gap", empty, 0);
    end
    ena = 0; rd_en = 0;

    // Mid-lane reset
    do_reset();
    x = 64'h4444_3333_2222_1111;
    put(x, 8'hFF, 1);
    rd_en = 1; cyc(); cyc(); rd_en = 0;
    chk("mid_lane2", dout, 16'h3333);
    rst = 1; cyc(); rst = 0;
    chk("mid_empty", empty, 1); chk("mid_level", level, 0); chk("mid_dout", dout, 0);
    chk("mid_last", rlast, 0);  chk("mid_strb", rstrb, 0);
    put(64'h8888_7777_6666_5555, 8'h3C, 0);
    chk("mid_new_lane0", dout, 16'h5555); chk("mid_new_strb", rstrb, 2'b00);

    // Randomized traffic with alternating fill/drain bias and occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int bias;
      bias  = ((c / 150) % 2 == 0) ? 3 : 1;
      ena   = ($urandom_range(0, 3) < bias);
      rd_en = ($urandom_range(0, 3) >= bias) || ($urandom_range(0, 3) == 0);
      din   = {$urandom, $urandom};
      strb  = 8'($urandom);
      last  = 1'($urandom);
      rst   = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 0; ena = 0; rd_en = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
